// File: rtl/adder_stream_accumulator.sv
// adder_stream_accumulator
//   Sums each packet of a valid/ready stream of 32-bit words through one
//   adder_32bit instance and counts the adder carry-outs. It then reports the
//   packet total, the carry count and the word count on a valid/ready result
//   port.
// Ports
//   clk, rst                clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready       input word handshake
//   in_data [31:0]          word to add
//   in_last                 marks the final word of a packet
//   out_valid/out_ready     result handshake
//   out_sum [31:0]          packet sum modulo 2^32
//   out_carries [CARRY_W]   C32=1 events in the packet (saturating)
//   out_count [COUNT_W]     words in the packet (saturating)
//
// adder_32bit
//   Ripple-free behavioural 32-bit adder: {C32, S} = A + B + C0.

module adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        C0,
  output logic [31:0] S,
  output logic        C32
);
  always_comb begin
    {C32, S} = {1'b0, A} + {1'b0, B} + {32'd0, C0};
  end
endmodule

module adder_stream_accumulator #(
  parameter int unsigned CARRY_W = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_sum,
  output logic [CARRY_W-1:0] out_carries,
  output logic [COUNT_W-1:0] out_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  localparam logic [CARRY_W-1:0] CARRY_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  state_t             state, state_n;
  logic [31:0]        acc;
  logic [CARRY_W-1:0] carries, carries_n;
  logic [COUNT_W-1:0] count, count_n;
  logic [31:0]        add_a, add_s;
  logic               add_c32;
  logic               accept;

  // Operand A is forced to zero in IDLE so a new packet never sees the
  // previous packet's accumulator.
  assign add_a = (state == IDLE) ? '0 : acc;

  adder_32bit u_adder (
    .A   (add_a),
    .B   (in_data),
    .C0  (1'b0),
    .S   (add_s),
    .C32 (add_c32)
  );

  always_comb begin
    in_ready  = (state != OUT);
    out_valid = (state == OUT);
    accept    = in_valid && (state != OUT);
    state_n   = state;
    carries_n = carries;
    count_n   = count;

    if (state == IDLE) begin
      carries_n = CARRY_W'(add_c32);
      count_n   = COUNT_W'(1);
    end else begin
      if (carries != CARRY_MAX)
        carries_n = carries + CARRY_W'(add_c32);
      if (count != COUNT_MAX)
        count_n = count + COUNT_W'(1);
    end

    case (state)
      IDLE, ACCUM: if (accept) state_n = in_last ? OUT : ACCUM;
      OUT:         if (out_ready) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      carries     <= '0;
      count       <= '0;
      out_sum     <= '0;
      out_carries <= '0;
      out_count   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc     <= add_s;
        carries <= carries_n;
        count   <= count_n;
        // Result registers capture the post-update totals on the same edge
        // that takes the last word, giving out_valid a one-cycle latency.
        if (in_last) begin
          out_sum     <= add_s;
          out_carries <= carries_n;
          out_count   <= count_n;
        end
      end
    end
  end
endmodule
